// File: rtl/multicycle_controller_pkg.sv
// Shared definitions for the multicycle RV32I control path: opcodes, ALU
// operation codes, datapath mux selects and the controller FSM state encoding.
// Optional build macro: MULTICYCLE_BNE_EN (adds BNE to the branch state).
package pa_riscv;

    // Opcodes handled by the controller
    localparam logic [6:0] LOAD       = 7'b0000011;
    localparam logic [6:0] STORE      = 7'b0100011;
    localparam logic [6:0] R_TYPE     = 7'b0110011;
    localparam logic [6:0] I_TYPE_ALU = 7'b0010011;
    localparam logic [6:0] BRANCH     = 7'b1100011;
    localparam logic [6:0] JAL        = 7'b1101111;

    // ALU operation codes, {funct7bit5, funct3}
    localparam logic [3:0] ADD = 4'b0000;
    localparam logic [3:0] SUB = 4'b1000;

    // Memory address select
    localparam logic ADR_PC     = 1'b0;
    localparam logic ADR_RESULT = 1'b1;

    // ALU input A select
    localparam logic [1:0] SRCA_PC    = 2'b00;
    localparam logic [1:0] SRCA_OLDPC = 2'b01;
    localparam logic [1:0] SRCA_RS1   = 2'b10;

    // ALU input B select
    localparam logic [1:0] SRCB_RS2  = 2'b00;
    localparam logic [1:0] SRCB_IMM  = 2'b01;
    localparam logic [1:0] SRCB_FOUR = 2'b10;

    // Result mux select
    localparam logic [1:0] RESULT_ALUOUT  = 2'b00;
    localparam logic [1:0] RESULT_MEMDATA = 2'b01;
    localparam logic [1:0] RESULT_ALU     = 2'b10;

    // Immediate format select
    localparam logic [1:0] IMM_I = 2'b00;
    localparam logic [1:0] IMM_S = 2'b01;
    localparam logic [1:0] IMM_B = 2'b10;
    localparam logic [1:0] IMM_J = 2'b11;

    // Controller FSM states
    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEMADR   = 4'd2,
        S_MEMREAD  = 4'd3,
        S_MEMWB    = 4'd4,
        S_MEMWRITE = 4'd5,
        S_EXECUTER = 4'd6,
        S_EXECUTEI = 4'd7,
        S_ALUWB    = 4'd8,
        S_BEQ      = 4'd9,
        S_JAL      = 4'd10
    } state_e;

    // Which B-type funct3 values the branch state can resolve
    function automatic logic branch_supported(input logic [2:0] funct3);
`ifdef MULTICYCLE_BNE_EN
        return (funct3 == 3'b000) || (funct3 == 3'b001);
`else
        return (funct3 == 3'b000);
`endif
    endfunction

endpackage

// File: rtl/multicycle_controller_alu_decoder.sv
// ALU operation decode for the multicycle controller. Address and target
// arithmetic uses ADD, the branch compare uses SUB, and the execute states
// pass the instruction's {funct7bit5, funct3} through. For I-type, funct7bit5
// only matters for shifts-right (funct3=101), so ADDI can never turn into SUB.
module multicycle_alu_decoder
    import pa_riscv::*;
#(
    parameter int ALU_OP_W = 4
) (
    input  logic [3:0]          i_state,
    input  logic [6:0]          i_operand,
    input  logic [2:0]          i_funct3,
    input  logic                i_funct7bit5,
    output logic [ALU_OP_W-1:0] o_aluLogicOperation
);

    logic [3:0] op4;
    logic       srai_bit;

    assign srai_bit = (i_operand == I_TYPE_ALU) && (i_funct3 == 3'b101) && i_funct7bit5;

    // Select the 4-bit operation, then zero-extend to the configured width
    always_comb begin
        op4 = ADD;
        case (i_state)
            S_EXECUTER: op4 = {i_funct7bit5, i_funct3};
            S_EXECUTEI: op4 = {srai_bit, i_funct3};
            S_BEQ:      op4 = SUB;
            default:    op4 = ADD;
        endcase
        o_aluLogicOperation      = '0;
        o_aluLogicOperation[3:0] = op4;
    end

endmodule

// File: rtl/multicycle_controller.sv
// Multicycle RV32I control unit: a Moore FSM stepping each instruction through
// fetch, decode, execute, memory and writeback, driving all datapath selects
// and write enables. Memory states stall on i_memReady when MEM_HANDSHAKE=1.
// Optional build macro: MULTICYCLE_BNE_EN (BNE resolved in the branch state).
module multicycle_controller
    import pa_riscv::*;
#(
    parameter int ALU_OP_W      = 4,
    parameter bit MEM_HANDSHAKE = 1'b1
) (
    input  logic                i_clk,
    input  logic                i_arst_n,
    input  logic [6:0]          i_operand,
    input  logic [2:0]          i_funct3,
    input  logic                i_funct7bit5,
    input  logic                i_zeroFlag,
    input  logic                i_memReady,
    output logic                o_memReq,
    output logic                o_pcWriteEn,
    output logic                o_irWriteEn,
    output logic                o_adrSrc,
    output logic                o_memWriteEn,
    output logic                o_regWriteEn,
    output logic [1:0]          o_immSrc,
    output logic [1:0]          o_aluInputASel,
    output logic [1:0]          o_aluInputBSel,
    output logic [ALU_OP_W-1:0] o_aluLogicOperation,
    output logic [1:0]          o_resultSel,
    output logic                o_illegalInstr,
    output logic [3:0]          o_state
);

    state_e state_q, state_d;
    logic   ready;
    logic   opcode_legal;
    logic   branch_taken;

    // Raw per-state strobes, gated by reset before leaving the block
    logic mem_req, pc_we, ir_we, mem_we, reg_we, illegal;

    assign ready = MEM_HANDSHAKE ? i_memReady : 1'b1;

`ifdef MULTICYCLE_BNE_EN
    assign branch_taken = i_zeroFlag ^ i_funct3[0];
`else
    assign branch_taken = i_zeroFlag;
`endif

    // Opcodes (and branch flavours) this controller can sequence
    always_comb begin
        opcode_legal = 1'b0;
        case (i_operand)
            LOAD, STORE, R_TYPE, I_TYPE_ALU, JAL: opcode_legal = 1'b1;
            BRANCH:                               opcode_legal = branch_supported(i_funct3);
            default:                              opcode_legal = 1'b0;
        endcase
    end

    // Next-state sequencing; memory states hold until the access completes
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_FETCH:    state_d = ready ? S_DECODE : S_FETCH;
            S_DECODE: begin
                state_d = S_FETCH;
                if (opcode_legal) begin
                    case (i_operand)
                        LOAD, STORE: state_d = S_MEMADR;
                        R_TYPE:      state_d = S_EXECUTER;
                        I_TYPE_ALU:  state_d = S_EXECUTEI;
                        BRANCH:      state_d = S_BEQ;
                        JAL:         state_d = S_JAL;
                        default:     state_d = S_FETCH;
                    endcase
                end
            end
            S_MEMADR:   state_d = (i_operand == STORE) ? S_MEMWRITE : S_MEMREAD;
            S_MEMREAD:  state_d = ready ? S_MEMWB : S_MEMREAD;
            S_MEMWB:    state_d = S_FETCH;
            S_MEMWRITE: state_d = ready ? S_FETCH : S_MEMWRITE;
            S_EXECUTER: state_d = S_ALUWB;
            S_EXECUTEI: state_d = S_ALUWB;
            S_ALUWB:    state_d = S_FETCH;
            S_BEQ:      state_d = S_FETCH;
            S_JAL:      state_d = S_ALUWB;
            default:    state_d = S_FETCH;
        endcase
    end

    // State register; reset abandons any instruction in flight
    always_ff @(posedge i_clk or negedge i_arst_n) begin
        if (!i_arst_n) state_q <= S_FETCH;
        else           state_q <= state_d;
    end

    // Moore outputs per state, plus the ready/zero-flag dependent strobes
    always_comb begin
        mem_req        = 1'b0;
        pc_we          = 1'b0;
        ir_we          = 1'b0;
        mem_we         = 1'b0;
        reg_we         = 1'b0;
        illegal        = 1'b0;
        o_adrSrc       = ADR_PC;
        o_aluInputASel = SRCA_PC;
        o_aluInputBSel = SRCB_RS2;
        o_resultSel    = RESULT_ALUOUT;
        case (state_q)
            S_FETCH: begin
                mem_req        = 1'b1;
                ir_we          = ready;
                pc_we          = ready;
                o_aluInputBSel = SRCB_FOUR;
                o_resultSel    = RESULT_ALU;
            end
            S_DECODE: begin
                // Branch/jump target lands in ALUOut ahead of need
                o_aluInputASel = SRCA_OLDPC;
                o_aluInputBSel = SRCB_IMM;
                illegal        = !opcode_legal;
            end
            S_MEMADR: begin
                o_aluInputASel = SRCA_RS1;
                o_aluInputBSel = SRCB_IMM;
            end
            S_MEMREAD: begin
                mem_req  = 1'b1;
                o_adrSrc = ADR_RESULT;
            end
            S_MEMWB: begin
                o_resultSel = RESULT_MEMDATA;
                reg_we      = 1'b1;
            end
            S_MEMWRITE: begin
                mem_req  = 1'b1;
                mem_we   = 1'b1;
                o_adrSrc = ADR_RESULT;
            end
            S_EXECUTER: o_aluInputASel = SRCA_RS1;
            S_EXECUTEI: begin
                o_aluInputASel = SRCA_RS1;
                o_aluInputBSel = SRCB_IMM;
            end
            S_ALUWB:    reg_we = 1'b1;
            S_BEQ: begin
                o_aluInputASel = SRCA_RS1;
                pc_we          = branch_taken;
            end
            S_JAL: begin
                // ALU produces the link address while PC takes the target
                o_aluInputASel = SRCA_OLDPC;
                o_aluInputBSel = SRCB_FOUR;
                pc_we          = 1'b1;
            end
            default: ;
        endcase
    end

    // Immediate format follows the opcode directly
    always_comb begin
        case (i_operand)
            STORE:   o_immSrc = IMM_S;
            BRANCH:  o_immSrc = IMM_B;
            JAL:     o_immSrc = IMM_J;
            default: o_immSrc = IMM_I;
        endcase
    end

    // No write or request can escape while reset is held
    assign o_memReq       = mem_req & i_arst_n;
    assign o_pcWriteEn    = pc_we   & i_arst_n;
    assign o_irWriteEn    = ir_we   & i_arst_n;
    assign o_memWriteEn   = mem_we  & i_arst_n;
    assign o_regWriteEn   = reg_we  & i_arst_n;
    assign o_illegalInstr = illegal & i_arst_n;
    assign o_state        = state_q;

    multicycle_alu_decoder #(
        .ALU_OP_W (ALU_OP_W)
    ) u_alu_dec (
        .i_state             (state_q),
        .i_operand           (i_operand),
        .i_funct3            (i_funct3),
        .i_funct7bit5        (i_funct7bit5),
        .o_aluLogicOperation (o_aluLogicOperation)
    );

endmodule

// File: tb/tb_multicycle_controller.sv
// Self-checking bench for multicycle_controller. Each instruction is turned into
// an expected per-cycle trace from its class (phase list plus stall counts),
// the bench drives i_memReady along that trace and compares every cycle.
module tb_multicycle_controller;
    import pa_riscv::*;

    logic       i_clk = 1'b0;
    logic       i_arst_n = 1'b0;
    logic [6:0] i_operand = 7'h00;
    logic [2:0] i_funct3 = 3'b000;
    logic       i_funct7bit5 = 1'b0;
    logic       i_zeroFlag = 1'b0;
    logic       i_memReady = 1'b1;
    logic       o_memReq, o_pcWriteEn, o_irWriteEn, o_adrSrc;
    logic       o_memWriteEn, o_regWriteEn, o_illegalInstr;
    logic [1:0] o_immSrc, o_aluInputASel, o_aluInputBSel, o_resultSel;
    logic [3:0] o_aluLogicOperation;
    logic [3:0] o_state;

    multicycle_controller dut (
        .i_clk (i_clk), .i_arst_n (i_arst_n), .i_operand (i_operand),
        .i_funct3 (i_funct3), .i_funct7bit5 (i_funct7bit5),
        .i_zeroFlag (i_zeroFlag), .i_memReady (i_memReady),
        .o_memReq (o_memReq), .o_pcWriteEn (o_pcWriteEn),
        .o_irWriteEn (o_irWriteEn), .o_adrSrc (o_adrSrc),
        .o_memWriteEn (o_memWriteEn), .o_regWriteEn (o_regWriteEn),
        .o_immSrc (o_immSrc), .o_aluInputASel (o_aluInputASel),
        .o_aluInputBSel (o_aluInputBSel),
        .o_aluLogicOperation (o_aluLogicOperation),
        .o_resultSel (o_resultSel), .o_illegalInstr (o_illegalInstr),
        .o_state (o_state)
    );

    always #5 i_clk = ~i_clk;

    typedef struct packed {
        logic [3:0] st;
        logic       memReq, pcWe, irWe, adr, memWe, regWe;
        logic [1:0] imm, a, b;
        logic [3:0] op;
        logic [1:0] res;
        logic       ill;
    } obs_t;

    obs_t exp_q[$];
    obs_t obs_q[$];
    logic rdy_q[$];
    int   checks = 0;
    int   failures = 0;

    // ---------------- reference model ----------------
    function automatic logic m_legal(input logic [6:0] opc, input logic [2:0] f3);
        if (opc == LOAD || opc == STORE || opc == R_TYPE || opc == I_TYPE_ALU || opc == JAL)
            return 1'b1;
`ifdef MULTICYCLE_BNE_EN
        if (opc == BRANCH) return (f3 == 3'd0) || (f3 == 3'd1);
`else
        if (opc == BRANCH) return (f3 == 3'd0);
`endif
        return 1'b0;
    endfunction

    function automatic logic m_taken(input logic [2:0] f3, input logic z);
`ifdef MULTICYCLE_BNE_EN
        return (f3 == 3'd1) ? !z : z;
`else
        return (f3 == 3'd0) ? z : 1'b0;
`endif
    endfunction

    // Expected outputs for one cycle spent in state s
    function automatic obs_t m_out(input state_e s, input logic rdy, input logic [6:0] opc,
                                   input logic [2:0] f3, input logic f7, input logic z);
        obs_t o;
        o = '0;
        o.st  = s;
        o.imm = (opc == STORE) ? 2'b01 : (opc == BRANCH) ? 2'b10 : (opc == JAL) ? 2'b11 : 2'b00;
        case (s)
            S_FETCH:    begin o.memReq = 1; o.b = 2'b10; o.res = 2'b10; o.irWe = rdy; o.pcWe = rdy; end
            S_DECODE:   begin o.a = 2'b01; o.b = 2'b01; o.ill = !m_legal(opc, f3); end
            S_MEMADR:   begin o.a = 2'b10; o.b = 2'b01; end
            S_MEMREAD:  begin o.memReq = 1; o.adr = 1; end
            S_MEMWB:    begin o.res = 2'b01; o.regWe = 1; end
            S_MEMWRITE: begin o.memReq = 1; o.adr = 1; o.memWe = 1; end
            S_EXECUTER: begin o.a = 2'b10; o.op = {f7, f3}; end
            S_EXECUTEI: begin o.a = 2'b10; o.b = 2'b01; o.op = {(f3 == 3'd5) ? f7 : 1'b0, f3}; end
            S_ALUWB:    o.regWe = 1;
            S_BEQ:      begin o.a = 2'b10; o.op = 4'b1000; o.pcWe = m_taken(f3, z); end
            S_JAL:      begin o.a = 2'b01; o.b = 2'b10; o.pcWe = 1; end
            default: ;
        endcase
        return o;
    endfunction

    function automatic void add_cyc(input state_e s, input logic r, input logic [6:0] opc,
                                    input logic [2:0] f3, input logic f7, input logic z);
        rdy_q.push_back(r);
        exp_q.push_back(m_out(s, r, opc, f3, f7, z));
    endfunction

    // Build the expected trace of one instruction from its class and stall counts
    function automatic void build(input logic [6:0] opc, input logic [2:0] f3, input logic f7,
                                  input logic z, input int fs, input int ms);
        exp_q.delete();
        rdy_q.delete();
        for (int k = 0; k < fs; k++) add_cyc(S_FETCH, 1'b0, opc, f3, f7, z);
        add_cyc(S_FETCH, 1'b1, opc, f3, f7, z);
        add_cyc(S_DECODE, 1'($urandom_range(0, 1)), opc, f3, f7, z);
        if (m_legal(opc, f3)) begin
            if (opc == LOAD) begin
                add_cyc(S_MEMADR, 1'($urandom_range(0, 1)), opc, f3, f7, z);
                for (int k = 0; k < ms; k++) add_cyc(S_MEMREAD, 1'b0, opc, f3, f7, z);
                add_cyc(S_MEMREAD, 1'b1, opc, f3, f7, z);
                add_cyc(S_MEMWB, 1'($urandom_range(0, 1)), opc, f3, f7, z);
            end else if (opc == STORE) begin
                add_cyc(S_MEMADR, 1'($urandom_range(0, 1)), opc, f3, f7, z);
                for (int k = 0; k < ms; k++) add_cyc(S_MEMWRITE, 1'b0, opc, f3, f7, z);
                add_cyc(S_MEMWRITE, 1'b1, opc, f3, f7, z);
            end else if (opc == R_TYPE) begin
                add_cyc(S_EXECUTER, 1'($urandom_range(0, 1)), opc, f3, f7, z);
                add_cyc(S_ALUWB, 1'($urandom_range(0, 1)), opc, f3, f7, z);
            end else if (opc == I_TYPE_ALU) begin
                add_cyc(S_EXECUTEI, 1'($urandom_range(0, 1)), opc, f3, f7, z);
                add_cyc(S_ALUWB, 1'($urandom_range(0, 1)), opc, f3, f7, z);
            end else if (opc == BRANCH) begin
                add_cyc(S_BEQ, 1'($urandom_range(0, 1)), opc, f3, f7, z);
            end else begin
                add_cyc(S_JAL, 1'($urandom_range(0, 1)), opc, f3, f7, z);
                add_cyc(S_ALUWB, 1'($urandom_range(0, 1)), opc, f3, f7, z);
            end
        end
    endfunction

    function automatic obs_t sample();
        obs_t o;
        o.st = o_state; o.memReq = o_memReq; o.pcWe = o_pcWriteEn; o.irWe = o_irWriteEn;
        o.adr = o_adrSrc; o.memWe = o_memWriteEn; o.regWe = o_regWriteEn; o.imm = o_immSrc;
        o.a = o_aluInputASel; o.b = o_aluInputBSel; o.op = o_aluLogicOperation;
        o.res = o_resultSel; o.ill = o_illegalInstr;
        return o;
    endfunction

    // Drive one instruction along the model's ready schedule (entered at posedge+1)
    task automatic drive(input logic [6:0] opc, input logic [2:0] f3, input logic f7, input logic z);
        i_operand = opc; i_funct3 = f3; i_funct7bit5 = f7; i_zeroFlag = z;
        obs_q.delete();
        for (int i = 0; i < rdy_q.size(); i++) begin
            i_memReady = rdy_q[i];
            @(negedge i_clk);
            obs_q.push_back(sample());
            @(posedge i_clk);
            #1;
        end
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        obs_t e;
        i_arst_n = 1'b0; i_memReady = 1'b1; i_operand = STORE;
        repeat (2) @(posedge i_clk);
        @(negedge i_clk);
        e = m_out(S_FETCH, 1'b1, STORE, 3'd0, 1'b0, 1'b0);
        e.memReq = 0; e.irWe = 0; e.pcWe = 0;
        checks++;
        if (sample() !== e) begin
            failures++;
            $display("FAIL reset_outputs got=%h exp=%h", sample(), e);
        end
        @(posedge i_clk); #1;
        i_arst_n = 1'b1;
    endtask

    task automatic test_add();
        logic [31:0] w;
        w = 32'h002081B3;
        build(w[6:0], w[14:12], w[30], 1'b0, 0, 0);
        drive(w[6:0], w[14:12], w[30], 1'b0);
        for (int i = 0; i < exp_q.size(); i++) begin
            checks++;
            if (obs_q[i] !== exp_q[i]) begin
                failures++;
                $display("FAIL add cyc=%0d got=%h exp=%h", i, obs_q[i], exp_q[i]);
            end
        end
        checks++;
        if (exp_q.size() != 4 || o_state !== 4'(S_FETCH)) begin
            failures++;
            $display("FAIL add_len len=%0d state=%0d exp_len=4", exp_q.size(), o_state);
        end
    endtask

    task automatic test_lw_stall();
        logic [31:0] w;
        w = 32'h0000A183;
        build(w[6:0], w[14:12], w[30], 1'b0, 0, 2);
        drive(w[6:0], w[14:12], w[30], 1'b0);
        for (int i = 0; i < exp_q.size(); i++) begin
            checks++;
            if (obs_q[i] !== exp_q[i]) begin
                failures++;
                $display("FAIL lw_stall cyc=%0d got=%h exp=%h", i, obs_q[i], exp_q[i]);
            end
        end
        checks++;
        if (exp_q.size() != 7 || o_state !== 4'(S_FETCH)) begin
            failures++;
            $display("FAIL lw_len len=%0d state=%0d exp_len=7", exp_q.size(), o_state);
        end
    endtask

    task automatic test_sw_stall();
        build(STORE, 3'b010, 1'b0, 1'b0, 1, 3);
        drive(STORE, 3'b010, 1'b0, 1'b0);
        for (int i = 0; i < exp_q.size(); i++) begin
            checks++;
            if (obs_q[i] !== exp_q[i]) begin
                failures++;
                $display("FAIL sw_stall cyc=%0d got=%h exp=%h", i, obs_q[i], exp_q[i]);
            end
        end
    endtask

    task automatic test_beq();
        for (int t = 0; t < 2; t++) begin
            build(BRANCH, 3'b000, 1'b0, (t == 0), 0, 0);
            drive(BRANCH, 3'b000, 1'b0, (t == 0));
            for (int i = 0; i < exp_q.size(); i++) begin
                checks++;
                if (obs_q[i] !== exp_q[i]) begin
                    failures++;
                    $display("FAIL beq zero=%0d cyc=%0d got=%h exp=%h", (t == 0), i, obs_q[i], exp_q[i]);
                end
            end
        end
    endtask

    task automatic test_jal();
        logic [31:0] w;
        w = 32'h008000EF;
        build(w[6:0], w[14:12], w[30], 1'b1, 0, 0);
        drive(w[6:0], w[14:12], w[30], 1'b1);
        for (int i = 0; i < exp_q.size(); i++) begin
            checks++;
            if (obs_q[i] !== exp_q[i]) begin
                failures++;
                $display("FAIL jal cyc=%0d got=%h exp=%h", i, obs_q[i], exp_q[i]);
            end
        end
    endtask

    task automatic test_illegal();
        logic [6:0] opcs [3];
        opcs[0] = 7'h7F; opcs[1] = BRANCH; opcs[2] = 7'h37;
        for (int t = 0; t < 3; t++) begin
            build(opcs[t], 3'b001, 1'b0, 1'b0, 0, 0);
            drive(opcs[t], 3'b001, 1'b0, 1'b0);
            for (int i = 0; i < exp_q.size(); i++) begin
                checks++;
                if (obs_q[i] !== exp_q[i]) begin
                    failures++;
                    $display("FAIL illegal opc=%h cyc=%0d got=%h exp=%h", opcs[t], i, obs_q[i], exp_q[i]);
                end
            end
        end
    endtask

    task automatic test_reset_midwrite();
        i_operand = STORE; i_funct3 = 3'b010; i_funct7bit5 = 1'b0; i_memReady = 1'b1;
        repeat (3) @(posedge i_clk);
        #1 i_memReady = 1'b0;
        @(negedge i_clk);
        checks++;
        if (o_state !== 4'(S_MEMWRITE) || o_memWriteEn !== 1'b1) begin
            failures++;
            $display("FAIL midwrite_pre state=%0d memWe=%b exp state=%0d memWe=1", o_state, o_memWriteEn, S_MEMWRITE);
        end
        #1 i_arst_n = 1'b0;
        #1;
        checks++;
        if (o_memWriteEn !== 1'b0 || o_memReq !== 1'b0 || o_state !== 4'(S_FETCH)) begin
            failures++;
            $display("FAIL midwrite_rst memWe=%b memReq=%b state=%0d exp 0 0 0", o_memWriteEn, o_memReq, o_state);
        end
        @(posedge i_clk); #1;
        i_arst_n = 1'b1;
        @(negedge i_clk);
        checks++;
        if (o_state !== 4'(S_FETCH) || o_irWriteEn !== 1'b0 || o_memReq !== 1'b1) begin
            failures++;
            $display("FAIL midwrite_post state=%0d irWe=%b memReq=%b exp 0 0 1", o_state, o_irWriteEn, o_memReq);
        end
        @(posedge i_clk); #1;
    endtask

    task automatic test_random();
        logic [6:0] opc;
        logic [2:0] f3;
        logic       f7, z;
        for (int n = 0; n < 80; n++) begin
            case ($urandom_range(0, 7))
                0: opc = LOAD;   1: opc = STORE; 2: opc = R_TYPE; 3: opc = I_TYPE_ALU;
                4: opc = BRANCH; 5: opc = JAL;   6: opc = 7'h7F;  default: opc = 7'h37;
            endcase
            f3 = 3'($urandom_range(0, 7));
            f7 = 1'($urandom_range(0, 1));
            z  = 1'($urandom_range(0, 1));
            build(opc, f3, f7, z, $urandom_range(0, 2), $urandom_range(0, 2));
            drive(opc, f3, f7, z);
            for (int i = 0; i < exp_q.size(); i++) begin
                checks++;
                if (obs_q[i] !== exp_q[i]) begin
                    failures++;
                    $display("FAIL random n=%0d opc=%h f3=%0d cyc=%0d got=%h exp=%h", n, opc, f3, i, obs_q[i], exp_q[i]);
                end
            end
        end
        checks++;
        if (o_state !== 4'(S_FETCH)) begin
            failures++;
            $display("FAIL random_end state=%0d exp=%0d", o_state, S_FETCH);
        end
    endtask

    initial begin
        test_reset();
        test_add();
        test_lw_stall();
        test_sw_stall();
        test_beq();
        test_jal();
        test_illegal();
        test_reset_midwrite();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
